binary_to_ascii_tx: RTL and testbench

Converts a binary value to fixed-width decimal ASCII and streams the digits to the UART transmitter, one byte per TX handshake. It is the transmit-side counterpart of the ATM's ASCII-digit receive path. It echoes account numbers, balances and amounts to the terminal in the same zero-padded, most-significant-digit-first format the receive path parses, optionally followed by CR LF.

---
 rtl/atm_ascii_pkg.sv | 21 ++
 rtl/bin2bcd_seq.sv | 55 +++++
 rtl/binary_to_ascii_tx.sv | 143 ++++++++++++++
 tb/tb_binary_to_ascii_tx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_ascii_pkg.sv
// ASCII constants and BCD types shared by the ATM terminal transmit and
// receive digit paths.
//   ASCII_ZERO / ASCII_CR / ASCII_LF / ASCII_QUIT : byte constants
//   bcd_digit_t                                    : one packed BCD nibble
//   pow10()                                        : elaboration-time helper
package atm_ascii_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_QUIT = 8'h71;

  typedef logic [3:0] bcd_digit_t;

  function automatic longint pow10(input int n);
    longint r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one input bit per clock.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   start    : load value and begin WIDTH iterations
//   value    : binary input, sampled on start
//   ready    : high when no conversion is in progress (bcd is valid after one)
//   bcd      : DIGITS BCD nibbles, index DIGITS-1 is most significant
module bin2bcd_seq
  import atm_ascii_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WIDTH-1:0]          value,
  output logic                      ready,
  output bcd_digit_t [DIGITS-1:0]   bcd
);

  localparam int TOT   = DIGITS * 4 + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  // BCD digits sit above the binary bits; every iteration adjusts the
  // digits and shifts the whole vector left by one.
  logic [TOT-1:0]   work_q;
  logic [TOT-1:0]   work_adj;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    work_adj = work_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_q[WIDTH+4*i +: 4] >= 4'd5)
        work_adj[WIDTH+4*i +: 4] = work_q[WIDTH+4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work_q <= '0;
      cnt_q  <= '0;
    end else if (start) begin
      work_q <= TOT'(value);
      cnt_q  <= CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      work_q <= work_adj << 1;
      cnt_q  <= cnt_q - CNT_W'(1);
    end
  end

  assign ready = (cnt_q == '0);
  assign bcd   = work_q[TOT-1 -: DIGITS*4];

endmodule

// File: rtl/binary_to_ascii_tx.sv
// Converts a binary value to zero-padded decimal ASCII and streams it to the
// UART transmitter, MSD first, optionally followed by CR LF.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   value_in    : binary value, latched when start is accepted
//   start_in    : request a transfer (ignored while busy)
//   abort_in    : cancel the transfer in progress
//   tx_done_in  : UART reports previous byte sent
//   tx_byte     : byte for the UART, valid while tx_dv
//   tx_dv       : one-cycle transmit strobe
//   busy        : transfer in progress
//   done        : one-cycle pulse after the final byte completes
//
// state   | meaning
// IDLE    | waiting for start
// CONVERT | double-dabble running
// SEND    | tx_dv high for the current byte
// WAIT    | waiting for tx_done_in
// FINISH  | done pulse; may accept the next start
module binary_to_ascii_tx
  import atm_ascii_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 3,
  parameter int APPEND_CRLF = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value_in,
  input  logic             start_in,
  input  logic             abort_in,
  input  logic             tx_done_in,
  output logic [7:0]       tx_byte,
  output logic             tx_dv,
  output logic             busy,
  output logic             done
);

  localparam int NBYTES = DIGITS + 2 * APPEND_CRLF;
  localparam int IDX_W  = ($clog2(NBYTES) > 0) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  if (((longint'(1) << WIDTH) - 1) >= pow10(DIGITS)) begin : g_bad_params
    $fatal(1, "binary_to_ascii_tx: WIDTH does not fit in DIGITS decimal digits");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_SEND,
    ST_WAIT,
    ST_FINISH
  } state_t;

  state_t                  state, state_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic                    load_byte;
  logic                    conv_start;
  logic                    conv_ready;
  logic [7:0]              sel_byte;
  bcd_digit_t [DIGITS-1:0] bcd;

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .value (value_in),
    .ready (conv_ready),
    .bcd   (bcd)
  );

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    load_byte  = 1'b0;
    conv_start = 1'b0;
    case (state)
      ST_IDLE, ST_FINISH: begin
        state_n = ST_IDLE;
        if (start_in) begin
          state_n    = ST_CONVERT;
          conv_start = 1'b1;
        end
      end
      ST_CONVERT: begin
        if (conv_ready) begin
          state_n   = ST_SEND;
          idx_n     = '0;
          load_byte = 1'b1;
        end
      end
      ST_SEND: state_n = ST_WAIT;
      ST_WAIT: begin
        if (tx_done_in) begin
          if (idx == LAST_IDX) begin
            state_n = ST_FINISH;
          end else begin
            state_n   = ST_SEND;
            idx_n     = idx + IDX_W'(1);
            load_byte = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // abort overrides everything, including a start seen in FINISH
    if (abort_in && state != ST_IDLE) begin
      state_n    = ST_IDLE;
      idx_n      = idx;
      load_byte  = 1'b0;
      conv_start = 1'b0;
    end
  end

  // Byte for the index about to be sent: digits MSD first, then CR, LF.
  always_comb begin
    sel_byte = ASCII_LF;
    if (idx_n == IDX_W'(DIGITS)) sel_byte = ASCII_CR;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_n == IDX_W'(i)) sel_byte = ASCII_ZERO + 8'(bcd[DIGITS-1-i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      tx_byte <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (load_byte) tx_byte <= sel_byte;
    end
  end

  assign tx_dv = (state == ST_SEND);
  assign busy  = (state == ST_CONVERT) || (state == ST_SEND) || (state == ST_WAIT);
  assign done  = (state == ST_FINISH);

endmodule

// File: tb/tb_binary_to_ascii_tx.sv
// Bench for binary_to_ascii_tx: dut_a with CR LF appended, dut_b digits only.
module tb_binary_to_ascii_tx;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] value_a = '0, value_b = '0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic       abort_a = 1'b0, abort_b = 1'b0;
  logic       txd_a = 1'b0, txd_b = 1'b0;
  logic [7:0] byte_a, byte_b;
  logic       dv_a, dv_b, busy_a, busy_b, done_a, done_b;

  always #5 clk = ~clk;

  binary_to_ascii_tx #(.WIDTH(WIDTH), .DIGITS(DIGITS), .APPEND_CRLF(1)) dut_a (
    .clk(clk), .rst(rst), .value_in(value_a), .start_in(start_a),
    .abort_in(abort_a), .tx_done_in(txd_a), .tx_byte(byte_a),
    .tx_dv(dv_a), .busy(busy_a), .done(done_a));

  binary_to_ascii_tx #(.WIDTH(WIDTH), .DIGITS(DIGITS), .APPEND_CRLF(0)) dut_b (
    .clk(clk), .rst(rst), .value_in(value_b), .start_in(start_b),
    .abort_in(abort_b), .tx_done_in(txd_b), .tx_byte(byte_b),
    .tx_dv(dv_b), .busy(busy_b), .done(done_b));

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int exp_done_a = 0, exp_done_b = 0, seen_done_a = 0, seen_done_b = 0;

  // Reference: decimal digit i (MSD first) by division, then CR, LF.
  function automatic logic [7:0] model_byte(input int v, input int i);
    int p;
    if (i < DIGITS) begin
      p = 1;
      for (int k = 0; k < DIGITS - 1 - i; k++) p = p * 10;
      return 8'(48 + (v / p) % 10);
    end
    return (i == DIGITS) ? 8'h0D : 8'h0A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_dv(input bit s);   return s ? dv_b : dv_a;     endfunction
  function automatic logic get_busy(input bit s); return s ? busy_b : busy_a; endfunction
  function automatic logic get_done(input bit s); return s ? done_b : done_a; endfunction
  function automatic logic [7:0] get_byte(input bit s); return s ? byte_b : byte_a; endfunction

  task automatic set_start(input bit s, input logic [7:0] v, input logic en);
    if (s) begin value_b = v; start_b = en; end
    else   begin value_a = v; start_a = en; end
  endtask

  task automatic set_txdone(input bit s, input logic en);
    if (s) txd_b = en; else txd_a = en;
  endtask

  task automatic push_exp(input bit s, input int v, input int count);
    for (int i = 0; i < count; i++) begin
      if (s) exp_b.push_back(model_byte(v, i));
      else   exp_a.push_back(model_byte(v, i));
    end
  endtask

  // Scoreboard monitor: every tx_dv pops one expected byte.
  always @(negedge clk) begin
    if (dv_a) begin
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tx_a: got byte %0h expected no transfer", byte_a);
      end else begin
        logic [7:0] e;
        e = exp_a.pop_front();
        if (byte_a !== e) begin
          errors++;
          $display("FAIL tx_byte_a: got %0h expected %0h", byte_a, e);
        end
      end
    end
    if (dv_b) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tx_b: got byte %0h expected no transfer", byte_b);
      end else begin
        logic [7:0] e;
        e = exp_b.pop_front();
        if (byte_b !== e) begin
          errors++;
          $display("FAIL tx_byte_b: got %0h expected %0h", byte_b, e);
        end
      end
    end
    if (done_a) seen_done_a++;
    if (done_b) seen_done_b++;
  end

  task automatic wait_dv(input bit s, output int lat);
    lat = 0;
    while (!get_dv(s) && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  // One full transfer; delay = cycles from tx_dv to the tx_done_in cycle.
  task automatic transfer(input bit s, input int v, input int delay, input bit inject);
    int n;
    int lat;
    logic [7:0] held;
    n = s ? DIGITS : DIGITS + 2;
    push_exp(s, v, n);
    if (s) exp_done_b++; else exp_done_a++;
    set_start(s, 8'(v), 1'b1);
    tick();
    set_start(s, 8'(v), 1'b0);
    check("busy_after_start", 32'(get_busy(s)), 1);
    wait_dv(s, lat);
    check("first_dv_latency", lat, WIDTH + 1);
    for (int b = 0; b < n; b++) begin
      held = get_byte(s);
      for (int k = 1; k <= delay; k++) begin
        tick();
        if (inject && b == 1 && k == 1) set_start(s, 8'd99, 1'b1);
        if (inject && b == 1 && k == 2) set_start(s, 8'd99, 1'b0);
        check("hold_dv", 32'(get_dv(s)), 0);
        check("hold_byte", 32'(get_byte(s)), 32'(held));
      end
      set_txdone(s, 1'b1);
      tick();
      set_txdone(s, 1'b0);
      if (b < n - 1) begin
        check("next_dv", 32'(get_dv(s)), 1);
      end else begin
        check("done_pulse", 32'(get_done(s)), 1);
        check("busy_at_done", 32'(get_busy(s)), 0);
        tick();
        check("done_one_cycle", 32'(get_done(s)), 0);
      end
    end
  endtask

  task automatic check_reset_a(input string name);
    check({name, "_byte"}, 32'(byte_a), 0);
    check({name, "_dv"}, 32'(dv_a), 0);
    check({name, "_busy"}, 32'(busy_a), 0);
    check({name, "_done"}, 32'(done_a), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v;
    int lat;
    int cnt;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_a("reset");
    check("reset_b_dv", 32'(dv_b), 0);
    check("reset_b_busy", 32'(busy_b), 0);
    check("reset_b_byte", 32'(byte_b), 0);

    transfer(0, 207, 5, 0);
    transfer(0, 0, 1, 0);
    transfer(0, 255, 2, 0);
    transfer(1, 0, 1, 0);
    transfer(1, 255, 5, 0);
    transfer(0, $urandom_range(0, 255), 200, 0);

    // start while busy must be ignored
    transfer(0, 123, 4, 1);
    repeat (10) tick();
    check("no_second_transfer", 32'(busy_a), 0);

    // abort together with the second tx_done_in
    v = $urandom_range(100, 255);
    push_exp(0, v, 2);
    set_start(0, 8'(v), 1'b1);
    tick();
    set_start(0, 8'(v), 1'b0);
    wait_dv(0, lat);
    check("abort_first_latency", lat, WIDTH + 1);
    tick();
    txd_a = 1'b1;
    tick();
    txd_a = 1'b0;
    check("abort_second_dv", 32'(dv_a), 1);
    tick();
    txd_a = 1'b1;
    abort_a = 1'b1;
    tick();
    txd_a = 1'b0;
    abort_a = 1'b0;
    check("abort_busy", 32'(busy_a), 0);
    check("abort_dv", 32'(dv_a), 0);
    cnt = 0;
    repeat (20) begin
      tick();
      if (dv_a || done_a || busy_a) cnt++;
    end
    check("abort_quiet", cnt, 0);
    transfer(0, 42, 3, 0);

    // reset during CONVERT
    set_start(0, 8'd150, 1'b1);
    tick();
    set_start(0, 8'd150, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_a("rst_convert");
    cnt = 0;
    repeat (15) begin
      tick();
      if (dv_a || busy_a) cnt++;
    end
    check("rst_convert_quiet", cnt, 0);

    // reset during WAIT, then a spurious tx_done_in
    v = $urandom_range(1, 255);
    push_exp(0, v, 1);
    set_start(0, 8'(v), 1'b1);
    tick();
    set_start(0, 8'(v), 1'b0);
    wait_dv(0, lat);
    check("rst_wait_latency", lat, WIDTH + 1);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_a("rst_wait");
    txd_a = 1'b1;
    tick();
    txd_a = 1'b0;
    cnt = 0;
    repeat (10) begin
      tick();
      if (dv_a || busy_a || done_a) cnt++;
    end
    check("spurious_done_quiet", cnt, 0);

    for (int i = 0; i < 12; i++) begin
      transfer(1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom_range(1, 6), 0);
    end

    repeat (5) tick();
    check("exp_a_drained", exp_a.size(), 0);
    check("exp_b_drained", exp_b.size(), 0);
    check("done_count_a", seen_done_a, exp_done_a);
    check("done_count_b", seen_done_b, exp_done_b);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
